// File: rtl/csi2tx_phy_pkg.sv
// rtl/csi2tx_phy_pkg.sv - shared types and constants for the D-PHY LP receive controller
//
// Contents:
//   lp_fsm_t       : LP receive FSM state encoding
//   LP_11..LP_00   : synchronised line states {dp,dn}
//   ESC_CMD_*      : escape entry command bytes
//   is_mark()      : true for the LP-10 / LP-01 mark states
package csi2tx_phy_pkg;

    typedef enum logic [3:0] {
        ST_STOP,
        ST_HS_RQST,
        ST_HS_PREP,
        ST_HS_RX,
        ST_ESC_RQST,
        ST_ESC_BRDG,
        ST_ESC_ENTRY,
        ST_ESC_CMD,
        ST_ESC_LPDT,
        ST_ESC_ULPS,
        ST_WAIT_STOP
    } lp_fsm_t;

    localparam logic [1:0] LP_11 = 2'b11;
    localparam logic [1:0] LP_10 = 2'b10;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_00 = 2'b00;

    localparam logic [7:0] ESC_CMD_LPDT    = 8'hE1;
    localparam logic [7:0] ESC_CMD_ULPS    = 8'h1E;
    localparam logic [7:0] ESC_CMD_TRIG_RST = 8'h62;
    localparam logic [7:0] ESC_CMD_TRIG_U3 = 8'h5D;
    localparam logic [7:0] ESC_CMD_TRIG_U4 = 8'h21;
    localparam logic [7:0] ESC_CMD_TRIG_U5 = 8'hA0;

    function automatic logic is_mark(input logic [1:0] s);
        return (s == LP_10) || (s == LP_01);
    endfunction

endpackage

// File: rtl/csi2tx_phy_sync.sv
// rtl/csi2tx_phy_sync.sv - N-stage flop synchroniser for asynchronous single-bit inputs
//
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, loads RESET_VAL into every stage
//   d     : asynchronous input
//   q     : synchronised output, STAGES cycles behind d
module csi2tx_phy_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= {STAGES{RESET_VAL}};
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/csi2tx_phy_lp_rx_ctrl.sv
// rtl/csi2tx_phy_lp_rx_ctrl.sv - LP receive controller for one D-PHY data lane
//
// Decodes synchronised LP line states into HS entry, escape commands, LPDT
// bytes and ULPS, and drives the AFE HS receiver enable.
//
// Ports:
//   clk_esc, rst_esc_n        : escape clock, asynchronous active-low reset
//   enable                    : lane enable, 0 parks the FSM and clears outputs
//   lp_rcv_dp/dn              : asynchronous LP receiver outputs
//   lp_cd_low/high            : asynchronous contention flags
//   hs_rx_en                  : HS receiver enable
//   lp_state                  : registered synchronised line state {dp,dn}
//   rx_esc_data, rx_valid_esc : LPDT byte and its one-cycle strobe
//   rx_lpdt_esc, rx_ulps_esc  : LPDT / ULPS mode active
//   rx_trigger_esc            : trigger pulses [0]=reset, [1..3]=unknown-3/4/5
//   err_*                     : one-cycle error pulses
module csi2tx_phy_lp_rx_ctrl
    import csi2tx_phy_pkg::*;
#(
    parameter int HS_SETTLE_CNT = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk_esc,
    input  logic       rst_esc_n,
    input  logic       enable,
    input  logic       lp_rcv_dp,
    input  logic       lp_rcv_dn,
    input  logic       lp_cd_low,
    input  logic       lp_cd_high,
    output logic       hs_rx_en,
    output logic [1:0] lp_state,
    output logic [7:0] rx_esc_data,
    output logic       rx_valid_esc,
    output logic       rx_lpdt_esc,
    output logic       rx_ulps_esc,
    output logic [3:0] rx_trigger_esc,
    output logic       err_esc,
    output logic       err_syncesc,
    output logic       err_control,
    output logic       err_contention
);

    localparam int              CNT_W    = (HS_SETTLE_CNT > 1) ? $clog2(HS_SETTLE_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HS_SETTLE_CNT - 1);

    logic       s_dp, s_dn, s_cd, primed;
    logic [1:0] s_line;
    logic       cd_q, cont_rise;

    lp_fsm_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       sr_q, sr_d, shifted, data_d;
    logic             pend_q, pend_d, pend_bit_q, pend_bit_d;
    logic             valid_d, err_esc_d, err_sync_d, err_ctrl_d, err_cont_d;
    logic [3:0]       trig_d;

    csi2tx_phy_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_dp (
        .clk(clk_esc), .rst_n(rst_esc_n), .d(lp_rcv_dp), .q(s_dp)
    );
    csi2tx_phy_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_dn (
        .clk(clk_esc), .rst_n(rst_esc_n), .d(lp_rcv_dn), .q(s_dn)
    );
    csi2tx_phy_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cd (
        .clk(clk_esc), .rst_n(rst_esc_n), .d(lp_cd_low | lp_cd_high), .q(s_cd)
    );
    // Rises once the data synchronisers hold real line samples rather than
    // their reset value, so the FSM cannot leave WAIT_STOP on a fake LP-11.
    csi2tx_phy_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_prime (
        .clk(clk_esc), .rst_n(rst_esc_n), .d(1'b1), .q(primed)
    );

    assign s_line    = {s_dp, s_dn};
    assign cont_rise = s_cd & ~cd_q;

    // Marks are held as pending and committed when the line returns to
    // LP-00; the mark-1 of an exit (LP-10 then LP-11) is therefore dropped
    // and never counted as data.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        pend_d     = pend_q;
        pend_bit_d = pend_bit_q;
        shifted    = 8'h00;
        data_d     = rx_esc_data;
        valid_d    = 1'b0;
        trig_d     = 4'b0000;
        err_esc_d  = 1'b0;
        err_sync_d = 1'b0;
        err_ctrl_d = 1'b0;
        err_cont_d = 1'b0;

        if (!enable) begin
            state_d   = ST_WAIT_STOP;
            cnt_d     = '0;
            bit_cnt_d = 3'd0;
            sr_d      = 8'h00;
            pend_d    = 1'b0;
            data_d    = 8'h00;
        end else if (!primed) begin
            state_d = ST_WAIT_STOP;
        end else if (cont_rise) begin
            err_cont_d = 1'b1;
            state_d    = ST_WAIT_STOP;
            pend_d     = 1'b0;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (s_line == LP_01) state_d = ST_HS_RQST;
                    else if (s_line == LP_10) state_d = ST_ESC_RQST;
                end
                ST_HS_RQST: begin
                    if (s_line == LP_00) begin
                        state_d = ST_HS_PREP;
                        cnt_d   = '0;
                    end else if (s_line == LP_11) begin
                        state_d = ST_STOP;
                    end else if (s_line == LP_10) begin
                        err_ctrl_d = 1'b1;
                        state_d    = ST_WAIT_STOP;
                    end
                end
                ST_HS_PREP: begin
                    if (s_line == LP_00) begin
                        if (cnt_q == CNT_LAST) state_d = ST_HS_RX;
                        else cnt_d = cnt_q + 1'b1;
                    end else if (s_line == LP_11) begin
                        state_d = ST_STOP;
                    end else begin
                        err_ctrl_d = 1'b1;
                        state_d    = ST_WAIT_STOP;
                    end
                end
                ST_HS_RX: begin
                    if (s_line == LP_11) state_d = ST_STOP;
                end
                ST_ESC_RQST: begin
                    if (s_line == LP_00) state_d = ST_ESC_BRDG;
                    else if (s_line == LP_11) state_d = ST_STOP;
                    else if (s_line == LP_01) begin
                        err_ctrl_d = 1'b1;
                        state_d    = ST_WAIT_STOP;
                    end
                end
                ST_ESC_BRDG: begin
                    if (s_line == LP_01) state_d = ST_ESC_ENTRY;
                    else if (s_line == LP_11) state_d = ST_STOP;
                    else if (s_line == LP_10) begin
                        err_ctrl_d = 1'b1;
                        state_d    = ST_WAIT_STOP;
                    end
                end
                ST_ESC_ENTRY: begin
                    if (s_line == LP_00) begin
                        state_d   = ST_ESC_CMD;
                        bit_cnt_d = 3'd0;
                        sr_d      = 8'h00;
                        pend_d    = 1'b0;
                    end else if (s_line == LP_11) begin
                        state_d = ST_STOP;
                    end else if (s_line == LP_10) begin
                        err_ctrl_d = 1'b1;
                        state_d    = ST_WAIT_STOP;
                    end
                end
                ST_ESC_CMD, ST_ESC_LPDT: begin
                    if (s_line == LP_00) begin
                        if (pend_q) begin
                            pend_d    = 1'b0;
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (state_q == ST_ESC_CMD) begin
                                shifted = {sr_q[6:0], pend_bit_q};
                                sr_d    = shifted;
                                if (bit_cnt_q == 3'd7) begin
                                    sr_d = 8'h00;
                                    case (shifted)
                                        ESC_CMD_LPDT:     state_d = ST_ESC_LPDT;
                                        ESC_CMD_ULPS:     state_d = ST_ESC_ULPS;
                                        ESC_CMD_TRIG_RST: begin trig_d = 4'b0001; state_d = ST_WAIT_STOP; end
                                        ESC_CMD_TRIG_U3:  begin trig_d = 4'b0010; state_d = ST_WAIT_STOP; end
                                        ESC_CMD_TRIG_U4:  begin trig_d = 4'b0100; state_d = ST_WAIT_STOP; end
                                        ESC_CMD_TRIG_U5:  begin trig_d = 4'b1000; state_d = ST_WAIT_STOP; end
                                        default: begin
                                            err_esc_d = 1'b1;
                                            state_d   = ST_WAIT_STOP;
                                        end
                                    endcase
                                end
                            end else begin
                                shifted = {pend_bit_q, sr_q[7:1]};
                                sr_d    = shifted;
                                if (bit_cnt_q == 3'd7) begin
                                    data_d  = shifted;
                                    valid_d = 1'b1;
                                end
                            end
                        end
                    end else if (s_line == LP_11) begin
                        state_d = ST_STOP;
                        pend_d  = 1'b0;
                        if (state_q == ST_ESC_LPDT && bit_cnt_q != 3'd0) err_sync_d = 1'b1;
                    end else if (lp_state == LP_00) begin
                        pend_d     = 1'b1;
                        pend_bit_d = (s_line == LP_10);
                    end else if (is_mark(lp_state) && lp_state != s_line) begin
                        err_ctrl_d = 1'b1;
                        pend_d     = 1'b0;
                        state_d    = ST_WAIT_STOP;
                    end
                end
                ST_ESC_ULPS: begin
                    if (s_line == LP_11) state_d = ST_STOP;
                end
                ST_WAIT_STOP: begin
                    if (s_line == LP_11) state_d = ST_STOP;
                end
                default: state_d = ST_WAIT_STOP;
            endcase
        end
    end

    always_ff @(posedge clk_esc or negedge rst_esc_n) begin
        if (!rst_esc_n) begin
            state_q        <= ST_WAIT_STOP;
            cnt_q          <= '0;
            bit_cnt_q      <= 3'd0;
            sr_q           <= 8'h00;
            pend_q         <= 1'b0;
            pend_bit_q     <= 1'b0;
            cd_q           <= 1'b0;
            lp_state       <= LP_11;
            hs_rx_en       <= 1'b0;
            rx_esc_data    <= 8'h00;
            rx_valid_esc   <= 1'b0;
            rx_lpdt_esc    <= 1'b0;
            rx_ulps_esc    <= 1'b0;
            rx_trigger_esc <= 4'b0000;
            err_esc        <= 1'b0;
            err_syncesc    <= 1'b0;
            err_control    <= 1'b0;
            err_contention <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            sr_q           <= sr_d;
            pend_q         <= pend_d;
            pend_bit_q     <= pend_bit_d;
            cd_q           <= s_cd;
            lp_state       <= s_line;
            hs_rx_en       <= (state_d == ST_HS_RX);
            rx_esc_data    <= data_d;
            rx_valid_esc   <= valid_d;
            rx_lpdt_esc    <= (state_d == ST_ESC_LPDT);
            rx_ulps_esc    <= (state_d == ST_ESC_ULPS);
            rx_trigger_esc <= trig_d;
            err_esc        <= err_esc_d;
            err_syncesc    <= err_sync_d;
            err_control    <= err_ctrl_d;
            err_contention <= err_cont_d;
        end
    end

endmodule

// File: tb/tb_csi2tx_phy_lp_rx_ctrl.sv
// tb/tb_csi2tx_phy_lp_rx_ctrl.sv - self-checking bench for csi2tx_phy_lp_rx_ctrl
module tb_csi2tx_phy_lp_rx_ctrl;

    logic       clk_esc    = 1'b0;
    logic       rst_esc_n  = 1'b0;
    logic       enable     = 1'b1;
    logic       lp_rcv_dp  = 1'b1;
    logic       lp_rcv_dn  = 1'b1;
    logic       lp_cd_low  = 1'b0;
    logic       lp_cd_high = 1'b0;
    logic       hs_rx_en;
    logic [1:0] lp_state;
    logic [7:0] rx_esc_data;
    logic       rx_valid_esc, rx_lpdt_esc, rx_ulps_esc;
    logic [3:0] rx_trigger_esc;
    logic       err_esc, err_syncesc, err_control, err_contention;

    always #5 clk_esc = ~clk_esc;

    csi2tx_phy_lp_rx_ctrl #(.HS_SETTLE_CNT(8), .SYNC_STAGES(2)) dut (
        .clk_esc(clk_esc), .rst_esc_n(rst_esc_n), .enable(enable),
        .lp_rcv_dp(lp_rcv_dp), .lp_rcv_dn(lp_rcv_dn),
        .lp_cd_low(lp_cd_low), .lp_cd_high(lp_cd_high),
        .hs_rx_en(hs_rx_en), .lp_state(lp_state),
        .rx_esc_data(rx_esc_data), .rx_valid_esc(rx_valid_esc),
        .rx_lpdt_esc(rx_lpdt_esc), .rx_ulps_esc(rx_ulps_esc),
        .rx_trigger_esc(rx_trigger_esc), .err_esc(err_esc),
        .err_syncesc(err_syncesc), .err_control(err_control),
        .err_contention(err_contention)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Event monitor: counts every high sample of the pulse outputs and logs bytes.
    int n_valid = 0, n_err_esc = 0, n_err_sync = 0, n_err_ctrl = 0, n_err_cont = 0;
    int n_trig[4] = '{0, 0, 0, 0};
    logic [7:0] rx_bytes[$];

    always @(negedge clk_esc) begin
        if (rx_valid_esc) begin
            rx_bytes.push_back(rx_esc_data);
            n_valid <= n_valid + 1;
        end
        if (err_esc)        n_err_esc  <= n_err_esc + 1;
        if (err_syncesc)    n_err_sync <= n_err_sync + 1;
        if (err_control)    n_err_ctrl <= n_err_ctrl + 1;
        if (err_contention) n_err_cont <= n_err_cont + 1;
        for (int i = 0; i < 4; i++)
            if (rx_trigger_esc[i]) n_trig[i] <= n_trig[i] + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drive a line state right after a clock edge and hold it for n edges;
    // returns 1 time unit after the last edge.
    task automatic hold(input logic [1:0] l, input int n);
        lp_rcv_dp = l[1];
        lp_rcv_dn = l[0];
        repeat (n) begin
            @(posedge clk_esc);
            #1;
        end
    endtask

    function automatic int rh();
        return int'($urandom_range(1, 3));
    endfunction

    task automatic send_bit(input logic b);
        hold(b ? 2'b10 : 2'b01, rh());
        hold(2'b00, rh());
    endtask

    task automatic send_msb(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_lsb(input logic [7:0] v, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(v[i]);
    endtask

    task automatic esc_entry();
        hold(2'b11, 4);
        hold(2'b10, rh());
        hold(2'b00, rh());
        hold(2'b01, rh());
        hold(2'b00, rh());
    endtask

    task automatic esc_exit();
        hold(2'b10, rh());
        hold(2'b11, 6);
    endtask

    // Escape command semantics: {lpdt, ulps, err_esc, trig[3:0]}
    function automatic logic [6:0] cmd_model(input logic [7:0] c);
        case (c)
            8'hE1:   return 7'b100_0000;
            8'h1E:   return 7'b010_0000;
            8'h62:   return 7'b000_0001;
            8'h5D:   return 7'b000_0010;
            8'h21:   return 7'b000_0100;
            8'hA0:   return 7'b000_1000;
            default: return 7'b001_0000;
        endcase
    endfunction

    task automatic run_cmd(input logic [7:0] cmd, input logic [6:0] exp, input string tag);
        int b_esc, b_ctrl, b_sync;
        int b_t[4];
        b_esc  = n_err_esc;
        b_ctrl = n_err_ctrl;
        b_sync = n_err_sync;
        for (int i = 0; i < 4; i++) b_t[i] = n_trig[i];
        esc_entry();
        send_msb(cmd);
        hold(2'b00, 4);
        check({tag, "_lpdt"}, int'(rx_lpdt_esc), int'(exp[6]));
        check({tag, "_ulps"}, int'(rx_ulps_esc), int'(exp[5]));
        esc_exit();
        check({tag, "_err_esc"}, n_err_esc - b_esc, int'(exp[4]));
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_trig%0d", tag, i), n_trig[i] - b_t[i], int'(exp[i]));
        check({tag, "_err_ctrl"}, n_err_ctrl - b_ctrl, 0);
        check({tag, "_err_sync"}, n_err_sync - b_sync, 0);
        check({tag, "_modes_off"}, int'({rx_lpdt_esc, rx_ulps_esc}), 0);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic       lpdt;
        logic       ulps;
        logic       err;
        logic [3:0] trig;
    } cmd_vec_t;

    cmd_vec_t vecs[8];

    initial begin
        int b0, b_ctrl, b_sync, b_esc, b_cont, b_v;
        logic [7:0] exp_q[$];
        logic [7:0] v, c;
        logic [7:0] lst[6];

        vecs[0] = '{8'hE1, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[1] = '{8'h1E, 1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[2] = '{8'h62, 1'b0, 1'b0, 1'b0, 4'b0001};
        vecs[3] = '{8'h5D, 1'b0, 1'b0, 1'b0, 4'b0010};
        vecs[4] = '{8'h21, 1'b0, 1'b0, 1'b0, 4'b0100};
        vecs[5] = '{8'hA0, 1'b0, 1'b0, 1'b0, 4'b1000};
        vecs[6] = '{8'h55, 1'b0, 1'b0, 1'b1, 4'b0000};
        vecs[7] = '{8'h00, 1'b0, 1'b0, 1'b1, 4'b0000};

        // Reset state
        repeat (3) @(posedge clk_esc);
        #1;
        check("reset_outputs", int'({hs_rx_en, rx_esc_data, rx_valid_esc, rx_lpdt_esc, rx_ulps_esc,
                                     rx_trigger_esc, err_esc, err_syncesc, err_control, err_contention}), 0);
        check("reset_lp_state", int'(lp_state), 3);
        rst_esc_n = 1'b1;
        hold(2'b11, 5);

        // HS entry timing
        b_ctrl = n_err_ctrl;
        hold(2'b01, 3);
        hold(2'b00, 10);
        check("hs_before_settle", int'(hs_rx_en), 0);
        hold(2'b00, 1);
        check("hs_at_settle", int'(hs_rx_en), 1);
        hold(2'b00, 9);
        check("hs_lp_state_00", int'(lp_state), 0);
        hold(2'b11, 2);
        check("hs_exit_minus1", int'(hs_rx_en), 1);
        hold(2'b11, 1);
        check("hs_exit", int'(hs_rx_en), 0);
        check("hs_no_err", n_err_ctrl - b_ctrl, 0);
        hold(2'b11, 3);

        // Table-driven escape command vectors
        for (int i = 0; i < 8; i++)
            run_cmd(vecs[i].cmd, {vecs[i].lpdt, vecs[i].ulps, vecs[i].err, vecs[i].trig},
                    $sformatf("vec%0d", i));

        // LPDT two bytes
        b0 = rx_bytes.size();
        b_v = n_valid;
        b_ctrl = n_err_ctrl; b_sync = n_err_sync; b_esc = n_err_esc;
        esc_entry();
        send_msb(8'hE1);
        hold(2'b00, 4);
        check("lpdt_mode", int'(rx_lpdt_esc), 1);
        send_lsb(8'hA5, 8);
        send_lsb(8'h3C, 8);
        esc_exit();
        check("lpdt_nvalid", n_valid - b_v, 2);
        if (rx_bytes.size() >= b0 + 2) begin
            check("lpdt_byte0", int'(rx_bytes[b0]), 8'hA5);
            check("lpdt_byte1", int'(rx_bytes[b0 + 1]), 8'h3C);
        end
        check("lpdt_data_hold", int'(rx_esc_data), 8'h3C);
        check("lpdt_errs", (n_err_ctrl - b_ctrl) + (n_err_sync - b_sync) + (n_err_esc - b_esc), 0);
        check("lpdt_off", int'(rx_lpdt_esc), 0);

        // ULPS held through 100 cycles of LP-00
        esc_entry();
        send_msb(8'h1E);
        hold(2'b00, 100);
        check("ulps_held", int'(rx_ulps_esc), 1);
        hold(2'b10, 2);
        check("ulps_mark", int'(rx_ulps_esc), 1);
        hold(2'b11, 3);
        check("ulps_exit", int'(rx_ulps_esc), 0);

        // Bad command, following marks ignored until LP-11
        b_esc = n_err_esc;
        b_v = n_trig[0];
        b_ctrl = n_err_ctrl;
        esc_entry();
        send_msb(8'h55);
        send_msb(8'h62);
        esc_exit();
        check("badcmd_err_esc", n_err_esc - b_esc, 1);
        check("badcmd_ignored", n_trig[0] - b_v, 0);
        check("badcmd_no_ctrl", n_err_ctrl - b_ctrl, 0);

        // LPDT exit after 5 bits
        b_sync = n_err_sync;
        b_v = n_valid;
        esc_entry();
        send_msb(8'hE1);
        send_lsb(8'h1B, 5);
        esc_exit();
        check("syncesc_pulse", n_err_sync - b_sync, 1);
        check("syncesc_novalid", n_valid - b_v, 0);

        // Mark changing directly to the other mark
        b_ctrl = n_err_ctrl;
        esc_entry();
        hold(2'b10, 2);
        hold(2'b01, 2);
        hold(2'b00, 4);
        check("ctrl_pulse", n_err_ctrl - b_ctrl, 1);
        hold(2'b11, 5);

        // Contention during HS_RX
        b_cont = n_err_cont;
        hold(2'b01, 3);
        hold(2'b00, 15);
        check("cont_pre_hs", int'(hs_rx_en), 1);
        lp_cd_low = 1'b1;
        hold(2'b00, 4);
        check("cont_pulse", n_err_cont - b_cont, 1);
        check("cont_hs_off", int'(hs_rx_en), 0);
        lp_cd_low = 1'b0;
        hold(2'b11, 5);

        // Enable drop in LPDT; lp_state keeps tracking
        esc_entry();
        send_msb(8'hE1);
        send_lsb(8'hFF, 3);
        enable = 1'b0;
        hold(2'b00, 1);
        check("disable_lpdt", int'(rx_lpdt_esc), 0);
        hold(2'b01, 3);
        check("disable_lp_state", int'(lp_state), 1);
        enable = 1'b1;
        hold(2'b11, 5);

        // Asynchronous reset mid-LPDT byte
        b_ctrl = n_err_ctrl; b_sync = n_err_sync; b_esc = n_err_esc;
        esc_entry();
        send_msb(8'hE1);
        send_lsb(8'hA5, 8);
        send_lsb(8'hFF, 3);
        hold(2'b10, 1);
        check("arst_pre_data", int'(rx_esc_data), 8'hA5);
        #2 rst_esc_n = 1'b0;
        #1;
        check("arst_outputs", int'({hs_rx_en, rx_esc_data, rx_valid_esc, rx_lpdt_esc, rx_ulps_esc,
                                    rx_trigger_esc, err_esc, err_syncesc, err_control, err_contention}), 0);
        check("arst_lp_state", int'(lp_state), 3);
        @(posedge clk_esc);
        @(posedge clk_esc);
        #1 rst_esc_n = 1'b1;
        hold(2'b00, 2);
        send_lsb(8'hFF, 4);
        b0 = rx_bytes.size();
        esc_entry();
        send_msb(8'hE1);
        send_lsb(8'h5A, 8);
        esc_exit();
        check("arst_after_nbytes", int'(rx_bytes.size()) - b0, 1);
        if (rx_bytes.size() > b0) check("arst_after_byte", int'(rx_bytes[b0]), 8'h5A);
        check("arst_no_errs", (n_err_ctrl - b_ctrl) + (n_err_sync - b_sync) + (n_err_esc - b_esc), 0);

        // Randomised transactions against the transaction-level model
        lst = '{8'hE1, 8'h1E, 8'h62, 8'h5D, 8'h21, 8'hA0};
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                int nb, k;
                nb = int'($urandom_range(1, 3));
                k  = int'($urandom_range(0, 7));
                exp_q.delete();
                b0 = rx_bytes.size();
                b_sync = n_err_sync;
                b_ctrl = n_err_ctrl;
                esc_entry();
                send_msb(8'hE1);
                for (int j = 0; j < nb; j++) begin
                    v = 8'($urandom);
                    exp_q.push_back(v);
                    send_lsb(v, 8);
                end
                v = 8'($urandom);
                send_lsb(v, k);
                esc_exit();
                check($sformatf("rnd%0d_nbytes", it), int'(rx_bytes.size()) - b0, nb);
                for (int j = 0; j < nb; j++)
                    if (b0 + j < rx_bytes.size())
                        check($sformatf("rnd%0d_byte%0d", it, j), int'(rx_bytes[b0 + j]), int'(exp_q[j]));
                check($sformatf("rnd%0d_syncesc", it), n_err_sync - b_sync, (k != 0) ? 1 : 0);
                check($sformatf("rnd%0d_ctrl", it), n_err_ctrl - b_ctrl, 0);
            end else begin
                if ($urandom_range(0, 1) == 1) c = lst[$urandom_range(0, 5)];
                else c = 8'($urandom);
                run_cmd(c, cmd_model(c), $sformatf("rnd%0d_cmd%02h", it, c));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
